clkgen_multi: RTL and testbench
===============================

// Module: clkgen_multi
// PURPOSE
//  Multi-channel fractional clock-enable generator; successor to the single-channel divider that drives the CPU hold.
//  Each channel produces an exact average-rate one-cycle tick (rate = freq/fref of the system clock).
//  Rates are reprogrammable at runtime (turbo, AY clock, beeper sampling, tape).
//  Adds per-channel stall with deferred-tick catch-up, for memory contention and wait states.
// PARAMETERS
//  CHANNELS  3   number of independent tick channels (1..8)
//  ACC_W     16  width of freq/fref/accumulator
//  PEND_W    4   width of per-channel pending-tick counter (saturates at 2**PEND_W-1)
//  DEF_FREQ  7   reset value of every channel's freq
//  DEF_FREF  50  reset value of every channel's fref (7/50 of 25 MHz = 3.5 MHz)
// PORTS
//  clock     in   1         system clock
//  reset     in   1         synchronous, active-high reset
//  cfg_we    in   1         write strobe: load cfg_freq/cfg_fref into channel cfg_sel
//  cfg_sel   in   SEL_W     channel index, SEL_W = max(1,$clog2(CHANNELS))
//  cfg_freq  in   ACC_W     numerator (ticks per fref clocks)
//  cfg_fref  in   ACC_W     denominator
//  enable    in   CHANNELS  =1 channel accumulates; =0 channel frozen (acc, pending held)
//  stall     in   CHANNELS  =1 suppress tick output, defer ticks into pending
//  ovr_clr   in   1         clears all overrun flags
//  tick      out  CHANNELS  registered one-cycle enable pulse (=1 active, usable as CPU hold)
//  cfg_err   out  CHANNELS  =1 channel config invalid (fref==0 or freq>fref); channel silent
//  overrun   out  CHANNELS  sticky: pending counter saturated and a tick was lost
// BEHAVIOUR
//  Reset: freq=DEF_FREQ, fref=DEF_FREF, acc=0, pending=0; tick, overrun = 0. cfg_err = validity of the defaults.
//  Per channel, per posedge, with enable=1 and cfg_err=0:
//    sum = acc + freq, computed ACC_W+1 bits wide.
//    raw = (sum >= fref).
//    acc <= raw ? sum - fref : sum. acc always stays < fref.
//  Tick output, all registered at the same edge as acc (zero extra latency):
//    stall=1: tick<=0; if raw, pending<=pending+1.
//    stall=1, saturation: if pending is already max, pending is unchanged and overrun<=1.
//    stall=0: tick <= raw | (pending!=0). If pending!=0 and !raw, pending<=pending-1. If raw & pending!=0, pending unchanged.
//    Net effect: at most one tick per cycle; the long-run tick count is preserved across stalls unless overrun occurs.
//  enable=0: acc and pending are frozen, and tick<=0. Stall has no effect while frozen.
//  freq==fref: raw every cycle (tick every clock). freq==0: never ticks.
//  cfg_we: at that edge, channel cfg_sel loads freq/fref, acc<=0, pending<=0, tick<=0.
//    cfg_err is updated from the new values. The new rate applies from the next edge.
//    cfg_sel >= CHANNELS: write ignored.
//  cfg_err=1: acc, pending, tick held at 0. The channel resumes only after a valid cfg_we.
//  ovr_clr at the same edge as a new saturation: the set wins (overrun stays 1).
//  reset dominates cfg_we, ovr_clr and all channel activity.
//  Channels are fully independent; there are no cross-channel interactions.
// TESTING
//  1 Defaults, enable=1, 50 clocks after reset release:
//    exactly 7 ticks on ch0; first tick high right after the 8th posedge (acc 49->56-50=6).
//  2 cfg_we ch1 freq=1 fref=1: tick ch1 high every cycle. Then freq=0: no tick for 100 cycles.
//  3 ch0 7/50, stall=1 for 100 cycles, then 0 (PEND_W=4):
//    pending reaches 14, no ticks during stall.
//    After release, 14 catch-up ticks interleave with new ticks, one per cycle.
//    Total over 300 cycles = 42. overrun=0.
//  4 ch0 1/1, stall=1 for 20 cycles: pending saturates at 15, overrun=1.
//    ovr_clr -> overrun=0. ovr_clr coincident with a new loss -> overrun stays 1.
//  5 cfg_we with fref=0, then freq=60/fref=50:
//    cfg_err=1 and tick silent in both cases.
//    Valid 7/50 write -> cfg_err=0, acc restarts from 0 (first tick after 8 edges).
//  6 reset asserted mid-stall with pending=5:
//    next edge tick=0, pending=0, rates back to DEF. enable=0 mid-run freezes acc; count resumes exactly.

Source files
------------

// File: rtl/clkgen_multi.sv
// Multi-channel fractional clock-enable generator: each channel emits freq ticks
// per fref clocks on average, with per-channel stall and deferred-tick catch-up.
module clkgen_multi #(
  parameter int CHANNELS = 3,
  parameter int ACC_W    = 16,
  parameter int PEND_W   = 4,
  parameter int DEF_FREQ = 7,
  parameter int DEF_FREF = 50,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [ACC_W-1:0]    cfg_freq,
  input  logic [ACC_W-1:0]    cfg_fref,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] stall,
  input  logic                ovr_clr,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] cfg_err,
  output logic [CHANNELS-1:0] overrun
);

  localparam logic [ACC_W-1:0] DEF_FREQ_V = ACC_W'(DEF_FREQ);
  localparam logic [ACC_W-1:0] DEF_FREF_V = ACC_W'(DEF_FREF);

  function automatic logic cfg_invalid(input logic [ACC_W-1:0] f, input logic [ACC_W-1:0] r);
    return (r == {ACC_W{1'b0}}) || (f > r);
  endfunction

  logic [ACC_W-1:0]    freq_r    [CHANNELS];
  logic [ACC_W-1:0]    fref_r    [CHANNELS];
  logic [ACC_W-1:0]    acc_r     [CHANNELS];
  logic [PEND_W-1:0]   pend_r    [CHANNELS];
  logic [ACC_W:0]      sum_s     [CHANNELS];
  logic [ACC_W-1:0]    acc_nxt_s [CHANNELS];
  logic [CHANNELS-1:0] raw_s, hit_s, run_s, lose_s, pend_nz_s, pend_max_s;
  logic [CHANNELS-1:0] tick_r, err_r, ovr_r;

  // Per-channel accumulator step and control decode.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_s[c]      = {1'b0, acc_r[c]} + {1'b0, freq_r[c]};
      raw_s[c]      = (sum_s[c] >= {1'b0, fref_r[c]});
      acc_nxt_s[c]  = raw_s[c] ? ACC_W'(sum_s[c] - {1'b0, fref_r[c]}) : ACC_W'(sum_s[c]);
      pend_nz_s[c]  = (pend_r[c] != {PEND_W{1'b0}});
      pend_max_s[c] = (pend_r[c] == {PEND_W{1'b1}});
      hit_s[c]      = cfg_we && (cfg_sel == SEL_W'(c));
      run_s[c]      = enable[c] && !err_r[c] && !hit_s[c];
      // A tick is lost only when it must be deferred into an already full counter.
      lose_s[c]     = run_s[c] && stall[c] && raw_s[c] && pend_max_s[c];
    end
  end

  // Channel state, registered tick and sticky overrun.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset) begin
        freq_r[c] <= DEF_FREQ_V;
        fref_r[c] <= DEF_FREF_V;
        acc_r[c]  <= {ACC_W{1'b0}};
        pend_r[c] <= {PEND_W{1'b0}};
        tick_r[c] <= 1'b0;
        err_r[c]  <= cfg_invalid(DEF_FREQ_V, DEF_FREF_V);
        ovr_r[c]  <= 1'b0;
      end else begin
        if (hit_s[c]) begin
          freq_r[c] <= cfg_freq;
          fref_r[c] <= cfg_fref;
          acc_r[c]  <= {ACC_W{1'b0}};
          pend_r[c] <= {PEND_W{1'b0}};
          tick_r[c] <= 1'b0;
          err_r[c]  <= cfg_invalid(cfg_freq, cfg_fref);
        end else if (err_r[c]) begin
          acc_r[c]  <= {ACC_W{1'b0}};
          pend_r[c] <= {PEND_W{1'b0}};
          tick_r[c] <= 1'b0;
        end else if (!enable[c]) begin
          tick_r[c] <= 1'b0;
        end else begin
          acc_r[c] <= acc_nxt_s[c];
          if (stall[c]) begin
            tick_r[c] <= 1'b0;
            if (raw_s[c] && !pend_max_s[c]) begin
              pend_r[c] <= pend_r[c] + PEND_W'(1);
            end
          end else begin
            tick_r[c] <= raw_s[c] || pend_nz_s[c];
            if (pend_nz_s[c] && !raw_s[c]) begin
              pend_r[c] <= pend_r[c] - PEND_W'(1);
            end
          end
        end
        ovr_r[c] <= lose_s[c] || (ovr_r[c] && !ovr_clr);
      end
    end
  end

  assign tick    = tick_r;
  assign cfg_err = err_r;
  assign overrun = ovr_r;

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed plus randomized bench for clkgen_multi; the reference model derives
// ticks from the count of accumulating edges (floor(k*freq/fref) increments).
module tb_clkgen_multi;

  localparam int CH   = 3;
  localparam int PMAX = 15;

  logic          clock;
  logic          reset;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [15:0]   cfg_freq;
  logic [15:0]   cfg_fref;
  logic [CH-1:0] enable;
  logic [CH-1:0] stall;
  logic          ovr_clr;
  logic [CH-1:0] tick;
  logic [CH-1:0] cfg_err;
  logic [CH-1:0] overrun;

  clkgen_multi dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_freq(cfg_freq), .cfg_fref(cfg_fref), .enable(enable), .stall(stall),
    .ovr_clr(ovr_clr), .tick(tick), .cfg_err(cfg_err), .overrun(overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: k counts accumulating edges since the last restart.
  longint m_freq [CH];
  longint m_fref [CH];
  longint m_k    [CH];
  int     m_pend [CH];
  bit     m_tick [CH];
  bit     m_err  [CH];
  bit     m_ovr  [CH];

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      bit lost;
      bit raw;
      lost = 1'b0;
      if (reset) begin
        m_freq[c] = 7; m_fref[c] = 50; m_k[c] = 0; m_pend[c] = 0;
        m_tick[c] = 1'b0; m_err[c] = 1'b0; m_ovr[c] = 1'b0;
        continue;
      end
      if (cfg_we && (int'(cfg_sel) == c)) begin
        m_freq[c] = longint'(cfg_freq);
        m_fref[c] = longint'(cfg_fref);
        m_k[c] = 0; m_pend[c] = 0; m_tick[c] = 1'b0;
        m_err[c] = (cfg_fref == 16'd0) || (cfg_freq > cfg_fref);
      end else if (m_err[c]) begin
        m_k[c] = 0; m_pend[c] = 0; m_tick[c] = 1'b0;
      end else if (!enable[c]) begin
        m_tick[c] = 1'b0;
      end else begin
        raw = ((m_k[c] + 1) * m_freq[c]) / m_fref[c] != (m_k[c] * m_freq[c]) / m_fref[c];
        m_k[c] = m_k[c] + 1;
        if (stall[c]) begin
          m_tick[c] = 1'b0;
          if (raw) begin
            if (m_pend[c] == PMAX) lost = 1'b1;
            else m_pend[c] = m_pend[c] + 1;
          end
        end else begin
          m_tick[c] = raw || (m_pend[c] > 0);
          if (!raw && m_pend[c] > 0) m_pend[c] = m_pend[c] - 1;
        end
      end
      m_ovr[c] = lost || (m_ovr[c] && !ovr_clr);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the same inputs the DUT sees, then outputs compared.
  task automatic step();
    logic [CH-1:0] et, ee, eo;
    model_edge();
    @(posedge clock);
    #1;
    for (int c = 0; c < CH; c++) begin
      et[c] = m_tick[c]; ee[c] = m_err[c]; eo[c] = m_ovr[c];
    end
    chk_vec("tick", tick, et);
    chk_vec("cfg_err", cfg_err, ee);
    chk_vec("overrun", overrun, eo);
  endtask

  task automatic write_cfg(input int sel, input int f, input int r);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_freq = 16'(f); cfg_fref = 16'(r);
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int cnt;
    int first;
    reset = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_freq = 16'd0; cfg_fref = 16'd0;
    enable = 3'b111; stall = 3'b000; ovr_clr = 1'b0;
    step();
    step();
    chk_vec("reset_tick", tick, 3'b000);
    chk_vec("reset_err", cfg_err, 3'b000);
    chk_vec("reset_ovr", overrun, 3'b000);
    reset = 1'b0;

    // Default 7/50: seven ticks in 50 clocks, first after the 8th edge.
    cnt = 0; first = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (tick[0]) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    chk_int("t1_count", cnt, 7);
    chk_int("t1_first", first, 8);

    // Full rate then zero rate on channel 1.
    write_cfg(1, 1, 1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin step(); if (tick[1]) cnt++; end
    chk_int("t2_every", cnt, 10);
    write_cfg(1, 0, 1);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin step(); if (tick[1]) cnt++; end
    chk_int("t2_never", cnt, 0);

    // Stall 100 cycles, then catch up; long-run count preserved.
    write_cfg(0, 7, 50);
    stall = 3'b001; cnt = 0;
    for (int k = 0; k < 100; k++) begin step(); if (tick[0]) cnt++; end
    chk_int("t3_stall_silent", cnt, 0);
    stall = 3'b000; first = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (tick[0]) begin cnt++; if (k < 15) first++; end
    end
    chk_int("t3_burst", first, 15);
    chk_int("t3_total", cnt, 42);
    chk_int("t3_overrun", int'(overrun[0]), 0);

    // Saturation, clear, and clear coincident with a fresh loss.
    write_cfg(0, 1, 1);
    stall = 3'b001;
    for (int k = 0; k < 20; k++) step();
    chk_int("t4_overrun_set", int'(overrun[0]), 1);
    stall = 3'b000; ovr_clr = 1'b1;
    step();
    chk_int("t4_overrun_clr", int'(overrun[0]), 0);
    stall = 3'b001;
    step();
    chk_int("t4_set_wins", int'(overrun[0]), 1);
    stall = 3'b000;
    step();
    ovr_clr = 1'b0;

    // Invalid configurations silence the channel; valid write restarts it.
    write_cfg(2, 5, 0);
    chk_int("t5_err_fref0", int'(cfg_err[2]), 1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin step(); if (tick[2]) cnt++; end
    write_cfg(2, 60, 50);
    chk_int("t5_err_gt", int'(cfg_err[2]), 1);
    for (int k = 0; k < 20; k++) begin step(); if (tick[2]) cnt++; end
    chk_int("t5_silent", cnt, 0);
    write_cfg(2, 7, 50);
    chk_int("t5_err_clear", int'(cfg_err[2]), 0);
    first = 0;
    for (int k = 1; k <= 10; k++) begin step(); if (tick[2] && first == 0) first = k; end
    chk_int("t5_first", first, 8);

    // Reset mid-stall with five ticks pending, then freeze/resume.
    write_cfg(0, 7, 50);
    stall = 3'b001;
    for (int k = 0; k < 36; k++) step();
    reset = 1'b1;
    step();
    chk_vec("t6_reset_tick", tick, 3'b000);
    reset = 1'b0; stall = 3'b000; cnt = 0;
    for (int k = 0; k < 5; k++) begin step(); if (tick[0]) cnt++; end
    enable = 3'b110; first = 0;
    for (int k = 0; k < 30; k++) begin step(); if (tick[0]) first++; end
    chk_int("t6_frozen", first, 0);
    enable = 3'b111;
    for (int k = 0; k < 45; k++) begin step(); if (tick[0]) cnt++; end
    chk_int("t6_resume_count", cnt, 7);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(199, 0) == 0);
      cfg_we   = ($urandom_range(15, 0) == 0);
      cfg_sel  = 2'($urandom_range(3, 0));
      cfg_freq = 16'($urandom_range(9, 0));
      cfg_fref = 16'($urandom_range(9, 0));
      enable   = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'b111;
      stall    = 3'($urandom_range(7, 0)) & 3'($urandom_range(7, 0));
      ovr_clr  = ($urandom_range(19, 0) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
